// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
package mcu_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJmpEx   = 4'd11,
    StHalt    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU_RES = 2'b00;
  localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_mcu.sv
// Main control FSM of the multi-cycle MIPS core: sequences memory, PC, IR, register file
// and ALU muxes; halts on illegal opcodes or memory timeouts until reset.
module multicycle_mcu
  import mcu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       eq,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       halted,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_debug
);

  localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

  state_t          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            illegal_op_q, illegal_op_d;
  logic            bus_err_q, bus_err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StFetch;
      wait_cnt_q   <= '0;
      illegal_op_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      illegal_op_q <= illegal_op_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    illegal_op_d = illegal_op_q;
    bus_err_d    = bus_err_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_we        = 1'b0;
    pc_en        = 1'b0;
    pc_src       = PC_SRC_ALU_RES;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_REGB;
    aluop        = ALUOP_ADD;
    reg_we       = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_we     = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:     state_d = StRtypeEx;
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_BEQ:       state_d = StBeqEx;
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJmpEx;
          default: begin
            state_d      = StHalt;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StRtypeEx: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_d   = StRtypeWb;
      end
      StRtypeWb: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
        state_d = StFetch;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_we  = 1'b1;
        state_d = StFetch;
      end
      StBeqEx: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        pc_src    = PC_SRC_ALU_OUT;
        pc_en     = eq;
        state_d   = StFetch;
      end
      StJmpEx: begin
        pc_src  = PC_SRC_JUMP;
        pc_en   = 1'b1;
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase

    // Stalled access: time out at MaxCnt, otherwise count up without wrapping.
    if (mem_req && !mem_ready) begin
      if ((MAX_WAIT != 0) && (wait_cnt_q == MaxCnt)) begin
        state_d   = StHalt;
        bus_err_d = 1'b1;
      end else if (wait_cnt_q != '1) begin
        wait_cnt_d = wait_cnt_q + CntW'(1);
      end
    end
    if (state_d != state_q) wait_cnt_d = '0;

    if (!reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_en   = 1'b0;
      reg_we  = 1'b0;
    end
  end

  assign halted      = (state_q == StHalt);
  assign illegal_op  = illegal_op_q;
  assign bus_err     = bus_err_q;
  assign state_debug = state_q;

endmodule

// File: tb/tb_multicycle_mcu.sv
// Self-checking bench for multicycle_mcu: directed scenarios plus random instruction streams
// compared against per-instruction expected cycle sequences.
module tb_multicycle_mcu;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       eq;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_we, pc_en;
  logic [1:0] pc_src, alu_src_b, aluop;
  logic       alu_src_a, reg_we, reg_dst, mem_to_reg;
  logic       halted, illegal_op, bus_err;
  logic [3:0] state_debug;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multicycle_mcu #(.MAX_WAIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .eq         (eq),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .aluop      (aluop),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .halted     (halted),
    .illegal_op (illegal_op),
    .bus_err    (bus_err),
    .state_debug(state_debug)
  );

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       req;
    logic       we;
    logic       io;
  } cyc_t;

  cyc_t seq_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [3:0] st, input logic rdy, input logic req, input logic we,
                      input logic io);
    cyc_t c;
    c.st  = st;
    c.rdy = rdy;
    c.req = req;
    c.we  = we;
    c.io  = io;
    seq_q.push_back(c);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] enables();
    return {mem_req, mem_we, ir_we, pc_en, reg_we};
  endfunction

  // Runs one instruction from FETCH: fw fetch wait states, mw data-access wait states.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic eqv);
    int n_ir = 0, n_pc = 0, n_reg = 0, n_mwe = 0, n_m2r = 0;
    int exp_pc, exp_reg, exp_mwe, exp_m2r;
    seq_q.delete();
    for (int i = 0; i < fw; i++) push(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(4'd1, rbit(), 1'b0, 1'b0, 1'b0);
    case (op)
      6'b100011: begin
        push(4'd2, rbit(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < mw; i++) push(4'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        push(4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        push(4'd4, rbit(), 1'b0, 1'b0, 1'b0);
      end
      6'b101011: begin
        push(4'd2, rbit(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < mw; i++) push(4'd5, 1'b0, 1'b1, 1'b1, 1'b1);
        push(4'd5, 1'b1, 1'b1, 1'b1, 1'b1);
      end
      6'b000000: begin
        push(4'd6, rbit(), 1'b0, 1'b0, 1'b0);
        push(4'd7, rbit(), 1'b0, 1'b0, 1'b0);
      end
      6'b001000: begin
        push(4'd9, rbit(), 1'b0, 1'b0, 1'b0);
        push(4'd10, rbit(), 1'b0, 1'b0, 1'b0);
      end
      6'b000100: push(4'd8, rbit(), 1'b0, 1'b0, 1'b0);
      6'b000010: push(4'd11, rbit(), 1'b0, 1'b0, 1'b0);
      default: ;
    endcase

    foreach (seq_q[i]) begin
      opcode    = op;
      eq        = eqv;
      mem_ready = seq_q[i].rdy;
      @(negedge clk);
      check("state", state_debug, seq_q[i].st);
      check("mem_req", mem_req, seq_q[i].req);
      if (seq_q[i].req) begin
        check("mem_we", mem_we, seq_q[i].we);
        check("iord", iord, seq_q[i].io);
      end
      n_ir  += int'(ir_we);
      n_pc  += int'(pc_en);
      n_reg += int'(reg_we);
      n_mwe += int'(mem_we);
      n_m2r += int'(reg_we && mem_to_reg);
      case (seq_q[i].st)
        4'd0: begin
          check("fetch_ir_we", ir_we, seq_q[i].rdy);
          check("fetch_pc_en", pc_en, seq_q[i].rdy);
          check("fetch_mux", {alu_src_a, alu_src_b, aluop, pc_src}, 7'b0_01_00_00);
        end
        4'd1: check("decode_mux", {alu_src_a, alu_src_b, aluop}, 5'b0_11_00);
        4'd2, 4'd9: check("imm_mux", {alu_src_a, alu_src_b, aluop}, 5'b1_10_00);
        4'd6: check("rtype_mux", {alu_src_a, alu_src_b, aluop}, 5'b1_00_10);
        4'd4: check("lw_wb", {reg_we, reg_dst, mem_to_reg}, 3'b101);
        4'd7: check("rtype_wb", {reg_we, reg_dst, mem_to_reg}, 3'b110);
        4'd10: check("addi_wb", {reg_we, reg_dst, mem_to_reg}, 3'b100);
        4'd8: begin
          check("beq_mux", {alu_src_a, alu_src_b, aluop, pc_src}, 7'b1_00_01_01);
          check("beq_pc_en", pc_en, eqv);
        end
        4'd11: check("jmp", {pc_en, pc_src}, 3'b1_10);
        default: ;
      endcase
      @(posedge clk);
      #1;
    end

    exp_pc  = 1 + ((op == 6'b000100) ? int'(eqv) : (op == 6'b000010) ? 1 : 0);
    exp_reg = (op == 6'b100011 || op == 6'b000000 || op == 6'b001000) ? 1 : 0;
    exp_mwe = (op == 6'b101011) ? mw + 1 : 0;
    exp_m2r = (op == 6'b100011) ? 1 : 0;
    check("ir_we_count", n_ir, 1);
    check("pc_en_count", n_pc, exp_pc);
    check("reg_we_count", n_reg, exp_reg);
    check("mem_we_count", n_mwe, exp_mwe);
    check("mem_to_reg_count", n_m2r, exp_m2r);
  endtask

  // Holds reset low for 3 cycles with mem_ready=1, then releases it just after a rising edge.
  task automatic do_reset();
    reset     = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_state", state_debug, 4'd0);
      check("rst_enables", enables(), 5'b0);
      check("rst_flags", {halted, illegal_op, bus_err}, 3'b000);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  initial begin
    logic [5:0] ops[6];
    ops[0] = 6'b100011;
    ops[1] = 6'b101011;
    ops[2] = 6'b000000;
    ops[3] = 6'b001000;
    ops[4] = 6'b000100;
    ops[5] = 6'b000010;
    reset     = 1'b0;
    opcode    = 6'd0;
    eq        = 1'b0;
    mem_ready = 1'b1;
    do_reset();

    // Directed instruction sequences.
    run_instr(6'b100011, 0, 0, 1'b0);
    run_instr(6'b101011, 0, 3, 1'b0);
    run_instr(6'b000100, 0, 0, 1'b0);
    run_instr(6'b000100, 0, 0, 1'b1);
    run_instr(6'b000010, 0, 0, 1'b0);
    run_instr(6'b000000, 1, 0, 1'b0);
    run_instr(6'b001000, 0, 0, 1'b1);

    // Illegal opcode parks the core until reset.
    run_instr(6'b111111, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      mem_ready = rbit();
      eq        = rbit();
      @(negedge clk);
      check("illegal_halt", {halted, illegal_op, bus_err, state_debug}, 7'b110_1111);
      check("halt_enables", enables(), 5'b0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    check("async_reset_clears", {illegal_op, halted, state_debug}, 6'b0);
    do_reset();

    // Fetch stalled past MAX_WAIT=4: five request cycles, then bus error.
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("timeout_wait", {state_debug, mem_req, ir_we, pc_en}, 7'b0000_100);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("timeout_halt", {halted, bus_err, illegal_op, state_debug}, 7'b110_1111);
    check("timeout_enables", enables(), 5'b0);
    @(posedge clk);
    #1;
    do_reset();

    // Ready arriving on the fifth request cycle wins over the timeout.
    run_instr(6'b100011, 4, 4, 1'b0);
    check("late_ready_no_bus_err", {bus_err, halted}, 2'b00);

    // Random legal instruction stream.
    for (int n = 0; n < 40; n++) begin
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 4), $urandom_range(0, 4), rbit());
      check("rand_flags", {halted, illegal_op, bus_err}, 3'b000);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
